// File: rtl/mips_prog_loader_if.sv
// ---------------------------------------------------------------------------
// mips_prog_loader_if
// Purpose : groups the instruction-word stream and the instruction-memory
//           write port of the program loader into a single bundle.
// Signals : s_data    [31:0]  instruction word stream
//           s_valid           s_data valid
//           s_ready           loader accepts a beat
//           mem_we            instruction-memory write strobe
//           mem_addr  [AW-1:0] write word address
//           mem_wdata [31:0]  write data
// Modports: slave  - the loader (consumes the stream, drives the memory port)
//           master - the environment (drives the stream, observes the port)
// ---------------------------------------------------------------------------
interface mips_prog_loader_if #(
    parameter int AW = 10
);
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/mips_prog_loader.sv
// ---------------------------------------------------------------------------
// mips_prog_loader
// Purpose : loads a block of instruction words from a valid/ready stream into
//           instruction memory, pulses cpu_init to restart the pipeline, runs
//           it until it reports HALTED (or a watchdog expires), then pulses
//           done and returns to IDLE.
// Params  : AW      - instruction-memory word-address width
//           RUN_MAX - maximum RUN cycles before the watchdog fires
// Ports   : clk1          sole clock, rising edge
//           rst_n         asynchronous active-low reset
//           i_ld_start    single-cycle load-and-run request
//           i_ld_base     first word address of the load
//           i_ld_count    number of words (0 = run without loading)
//           i_ld_abort    return to IDLE from any state
//           bus           stream in / memory write port out (slave modport)
//           o_cpu_init    one-cycle pipeline init pulse (PC=0, flags cleared)
//           o_cpu_run     pipeline run enable
//           i_cpu_halted  HALTED flag from the pipeline
//           o_busy        high in every state except IDLE
//           o_done        one-cycle completion pulse
//           o_timeout     sticky watchdog flag
//           o_err         sticky flag: ld_start seen while busy
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module mips_prog_loader #(
    parameter int AW      = 10,
    parameter int RUN_MAX = 1024
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                i_ld_start,
    input  logic [AW-1:0]       i_ld_base,
    input  logic [AW-1:0]       i_ld_count,
    input  logic                i_ld_abort,
    mips_prog_loader_if.slave   bus,
    output logic                o_cpu_init,
    output logic                o_cpu_run,
    input  logic                i_cpu_halted,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_timeout,
    output logic                o_err
);

    // Watchdog width: enough bits to hold RUN_MAX-1.
    localparam int CW = (RUN_MAX > 1) ? $clog2(RUN_MAX) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(RUN_MAX - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]    r_state;
    logic [AW-1:0] r_base;
    logic [AW-1:0] r_count;
    logic [AW-1:0] r_idx;
    logic [CW-1:0] r_wdog;

    logic          r_s_ready;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_cpu_init;
    logic          r_cpu_run;
    logic          r_busy;
    logic          r_done;
    logic          r_timeout;
    logic          r_err;

    logic [2:0]    w_state_next;
    logic          w_accept;
    logic          w_last_beat;
    logic          w_wdog_hit;
    logic          w_start_idle;
    logic          w_start_busy;

    // A beat is taken whenever the stream is valid while we are in LOAD
    // (s_ready mirrors the LOAD state exactly).
    assign w_accept     = (r_state == ST_LOAD) && bus.s_valid;
    assign w_last_beat  = w_accept && (r_idx == (r_count - 1'b1));
    // Halt has priority over the watchdog when both land on the same cycle.
    assign w_wdog_hit   = (r_state == ST_RUN) && !i_cpu_halted && (r_wdog == WD_LAST);
    assign w_start_idle = (r_state == ST_IDLE) && i_ld_start && !i_ld_abort;
    assign w_start_busy = (r_state != ST_IDLE) && i_ld_start && !i_ld_abort;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_ld_start) begin
                    w_state_next = (i_ld_count != '0) ? ST_LOAD : ST_RELEASE;
                end
            end
            ST_LOAD: begin
                if (w_last_beat) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (i_cpu_halted || w_wdog_hit) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Abort overrides every other event.
        if (i_ld_abort) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_wdog      <= '0;
            r_s_ready   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_init  <= 1'b0;
            r_cpu_run   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Status outputs are decoded from the next state so that they
            // line up with the state register rather than lagging it.
            r_s_ready  <= (w_state_next == ST_LOAD);
            r_cpu_init <= (w_state_next == ST_RELEASE);
            r_cpu_run  <= (w_state_next == ST_RUN);
            r_busy     <= (w_state_next != ST_IDLE);
            r_done     <= (w_state_next == ST_DONE);

            // Write strobe follows the accepted beat by one cycle; an abort on
            // the accepting edge drops the write.
            r_mem_we <= w_accept && !i_ld_abort;
            if (w_accept) begin
                r_mem_addr  <= r_base + r_idx;   // wraps modulo 2^AW
                r_mem_wdata <= bus.s_data;
                r_idx       <= r_idx + 1'b1;
            end

            if (w_start_idle) begin
                r_base    <= i_ld_base;
                r_count   <= i_ld_count;
                r_idx     <= '0;
                r_err     <= 1'b0;
                r_timeout <= 1'b0;
            end else if (w_start_busy) begin
                r_err <= 1'b1;
            end

            if (w_wdog_hit && !i_ld_abort) begin
                r_timeout <= 1'b1;
            end

            // Counter only runs in RUN, so it is already zero on RUN entry.
            if (r_state == ST_RUN) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign bus.s_ready   = r_s_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign o_cpu_init    = r_cpu_init;
    assign o_cpu_run     = r_cpu_run;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;
    assign o_err         = r_err;

endmodule

// File: tb/tb_mips_prog_loader.sv
module tb_mips_prog_loader;

    localparam int AW = 10;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b0;

    // DUT A: default watchdog
    logic          ld_start = 1'b0;
    logic [AW-1:0] ld_base = '0;
    logic [AW-1:0] ld_count = '0;
    logic          ld_abort = 1'b0;
    logic          cpu_halted = 1'b0;
    logic          cpu_init, cpu_run, busy, done, timeout, err;

    // DUT B: RUN_MAX = 16
    logic          ld_start_b = 1'b0;
    logic [AW-1:0] ld_count_b = '0;
    logic          ld_abort_b = 1'b0;
    logic          cpu_halted_b = 1'b0;
    logic          cpu_init_b, cpu_run_b, busy_b, done_b, timeout_b, err_b;

    mips_prog_loader_if #(.AW(AW)) bus_a ();
    mips_prog_loader_if #(.AW(AW)) bus_b ();

    mips_prog_loader #(.AW(AW), .RUN_MAX(1024)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .i_ld_start(ld_start), .i_ld_base(ld_base), .i_ld_count(ld_count),
        .i_ld_abort(ld_abort), .bus(bus_a),
        .o_cpu_init(cpu_init), .o_cpu_run(cpu_run), .i_cpu_halted(cpu_halted),
        .o_busy(busy), .o_done(done), .o_timeout(timeout), .o_err(err)
    );

    mips_prog_loader #(.AW(AW), .RUN_MAX(16)) dut_b (
        .clk1(clk1), .rst_n(rst_n),
        .i_ld_start(ld_start_b), .i_ld_base(10'd0), .i_ld_count(ld_count_b),
        .i_ld_abort(ld_abort_b), .bus(bus_b),
        .o_cpu_init(cpu_init_b), .o_cpu_run(cpu_run_b), .i_cpu_halted(cpu_halted_b),
        .o_busy(busy_b), .o_done(done_b), .o_timeout(timeout_b), .o_err(err_b)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // ---------------- scoreboard for memory writes of DUT A ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t           sb[$];
    int            n_wr = 0;
    int            n_done = 0;
    logic [AW-1:0] last_addr = '0;

    always @(negedge clk1) begin
        if (done === 1'b1) n_done++;
        if (bus_a.mem_we === 1'b1) begin
            n_wr++;
            last_addr = bus_a.mem_addr;
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(bus_a.mem_addr), 64'(e.addr));
                check("wr_data", 64'(bus_a.mem_wdata), 64'(e.data));
            end
        end
        // DUT B never receives beats
        if (bus_b.mem_we === 1'b1) check("b_unexpected_write", 1, 0);
    end

    logic [31:0] prog [8] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                              32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};

    task automatic tick();
        @(posedge clk1); #1;
    endtask

    // Drives one load. Leaves the caller one step after the edge that took the
    // last beat (loader should then be in RELEASE).
    task automatic do_load(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                           input bit gaps, input bit use_prog, input int err_at);
        int k = 0;
        int cyc = 0;
        ld_start = 1'b1; ld_base = base; ld_count = cnt;
        tick();
        ld_start = 1'b0;
        check("start_s_ready", 64'(bus_a.s_ready), 1);
        check("start_busy", 64'(busy), 1);
        check("start_err_clear", 64'(err), 0);
        while (k < int'(cnt) && cyc < 100) begin
            bus_a.s_valid = gaps ? (cyc % 2 == 1) : 1'b1;
            bus_a.s_data  = use_prog ? prog[k % 8] : $urandom;
            ld_start      = (cyc == err_at);
            if (cyc == err_at) begin ld_base = 10'd500; ld_count = 10'd1; end
            @(negedge clk1);
            if (bus_a.s_valid && bus_a.s_ready) begin
                sb.push_back('{addr: base + AW'(k), data: bus_a.s_data});
                k++;
            end
            tick();
            cyc++;
        end
        ld_start = 1'b0;
        bus_a.s_valid = 1'b0;
        if (k < int'(cnt)) check("load_budget", 64'(k), 64'(cnt));
    endtask

    // Expects to be in RELEASE; raises halt on RUN cycle `delay`.
    task automatic run_phase(input int delay);
        check("release_cpu_init", 64'(cpu_init), 1);
        check("release_s_ready", 64'(bus_a.s_ready), 0);
        for (int i = 1; i <= delay; i++) begin
            tick();
            if (i == 1) check("run_entry", 64'({cpu_run, cpu_init}), 64'(2'b10));
            if (i == delay) cpu_halted = 1'b1;
        end
        tick();
        cpu_halted = 1'b0;
        check("done_pulse", 64'({done, cpu_run, timeout}), 64'(3'b100));
        tick();
        check("back_idle", 64'({done, busy}), 64'(2'b00));
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] count;
        bit            gaps;
        bit            use_prog;
        int            err_at;
        int            halt_delay;
        logic [AW-1:0] exp_last;
        logic          exp_err;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{base: 10'd0,    count: 10'd8, gaps: 0, use_prog: 1, err_at: -1, halt_delay: 30, exp_last: 10'd7,   exp_err: 0};
        vecs[1] = '{base: 10'd1022, count: 10'd4, gaps: 1, use_prog: 0, err_at: -1, halt_delay: 5,  exp_last: 10'd1,   exp_err: 0};
        vecs[2] = '{base: 10'd100,  count: 10'd3, gaps: 0, use_prog: 0, err_at: 1,  halt_delay: 1,  exp_last: 10'd102, exp_err: 1};
        vecs[3] = '{base: 10'd1023, count: 10'd2, gaps: 1, use_prog: 0, err_at: -1, halt_delay: 10, exp_last: 10'd0,   exp_err: 0};

        bus_a.s_valid = 1'b0; bus_a.s_data = '0;
        bus_b.s_valid = 1'b0; bus_b.s_data = '0;

        #12;
        check("reset_outputs", 64'({bus_a.s_ready, bus_a.mem_we, cpu_init, cpu_run, busy, done, timeout, err,
                                    bus_a.mem_addr, bus_a.mem_wdata}), 0);
        @(posedge clk1); #3 rst_n = 1'b1;
        tick();

        // ---------------- table-driven loads ----------------
        for (int v = 0; v < 4; v++) begin
            int wr0;
            wr0 = n_wr;
            do_load(vecs[v].base, vecs[v].count, vecs[v].gaps, vecs[v].use_prog, vecs[v].err_at);
            check($sformatf("v%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
            run_phase(vecs[v].halt_delay);
            check($sformatf("v%0d_nwrites", v), 64'(n_wr - wr0), 64'(vecs[v].count));
            check($sformatf("v%0d_last_addr", v), 64'(last_addr), 64'(vecs[v].exp_last));
            check($sformatf("v%0d_sb_empty", v), 64'(sb.size()), 0);
        end

        // ---------------- ld_count == 0, then abort during RUN ----------------
        begin
            int wr0, d0;
            wr0 = n_wr;
            ld_start = 1'b1; ld_count = '0; ld_base = 10'd33;
            tick();
            ld_start = 1'b0;
            check("cnt0_init", 64'({cpu_init, bus_a.s_ready, bus_a.mem_we}), 64'(3'b100));
            repeat (5) tick();
            check("cnt0_running", 64'(cpu_run), 1);
            d0 = n_done;
            ld_abort = 1'b1;
            tick();
            ld_abort = 1'b0;
            check("abort_run_idle", 64'({busy, cpu_run, done}), 0);
            repeat (3) tick();
            check("abort_no_done", 64'(n_done - d0), 0);
            check("cnt0_no_writes", 64'(n_wr - wr0), 0);
        end

        // ---------------- abort during LOAD with a beat on the same edge ----------------
        begin
            int wr0;
            wr0 = n_wr;
            ld_start = 1'b1; ld_base = 10'd200; ld_count = 10'd4;
            tick();
            for (int b = 0; b < 2; b++) begin
                ld_start = (b == 1);      // busy request -> err
                bus_a.s_valid = 1'b1; bus_a.s_data = 32'hA0A0_0000 + 32'(b);
                @(negedge clk1);
                sb.push_back('{addr: 10'd200 + AW'(b), data: bus_a.s_data});
                tick();
            end
            ld_start = 1'b0;
            bus_a.s_data = 32'hDEAD_BEEF; ld_abort = 1'b1;
            tick();
            ld_abort = 1'b0; bus_a.s_valid = 1'b0;
            check("abort_load_state", 64'({busy, bus_a.s_ready, bus_a.mem_we}), 0);
            check("abort_err_kept", 64'(err), 1);
            repeat (3) tick();
            check("abort_load_writes", 64'(n_wr - wr0), 2);
        end

        // ---------------- async reset after 3rd beat of 8 ----------------
        begin
            int wr0;
            ld_start = 1'b1; ld_base = 10'd0; ld_count = 10'd8;
            tick();
            ld_start = 1'b0;
            for (int b = 0; b < 3; b++) begin
                bus_a.s_valid = 1'b1; bus_a.s_data = prog[b];
                @(negedge clk1);
                sb.push_back('{addr: AW'(b), data: bus_a.s_data});
                tick();
            end
            @(negedge clk1); #1;         // 3rd write already scored
            wr0 = n_wr;
            rst_n = 1'b0;
            #1;
            check("rst_mid_load", 64'({bus_a.s_ready, bus_a.mem_we, cpu_init, cpu_run, busy, done, timeout, err,
                                       bus_a.mem_addr, bus_a.mem_wdata}), 0);
            tick();
            #2 rst_n = 1'b1;
            repeat (4) tick();
            bus_a.s_valid = 1'b0;
            check("rst_no_writes", 64'(n_wr - wr0), 0);
            check("rst_idle", 64'({busy, bus_a.s_ready}), 0);
            check("rst_sb_empty", 64'(sb.size()), 0);
        end

        // ---------------- watchdog on DUT B ----------------
        for (int t = 0; t < 2; t++) begin
            ld_start_b = 1'b1; ld_count_b = '0;
            tick();
            ld_start_b = 1'b0;
            check($sformatf("wd%0d_init", t), 64'(cpu_init_b), 1);
            for (int i = 1; i <= 16; i++) begin
                tick();
                if (i == 16) begin
                    check($sformatf("wd%0d_run16", t), 64'({cpu_run_b, done_b}), 64'(2'b10));
                    cpu_halted_b = (t == 1);
                end
            end
            tick();
            cpu_halted_b = 1'b0;
            check($sformatf("wd%0d_done", t), 64'({done_b, cpu_run_b, timeout_b}),
                  (t == 0) ? 64'(3'b101) : 64'(3'b100));
            tick();
            check($sformatf("wd%0d_idle", t), 64'({done_b, busy_b, timeout_b}),
                  (t == 0) ? 64'(3'b001) : 64'(3'b000));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

endmodule
